hc165_reader: RTL and testbench
===============================

Name: hc165_reader

Overview:
- Host-side controller for one or more daisy-chained HC165-style parallel-in/serial-out registers.
- Drives the chain's active-low load strobe (shld) and shift clock (sclk), and samples the chain's serial output q.
- Reassembles the sampled bits into one parallel word and presents it with a valid/ready handshake.
- Sits directly downstream of the PISO chain; feeds the system's input-capture logic.

Parameters:
- WIDTH, 8, bits per PISO device.
- CHIPS, 1, number of daisy-chained devices.
- CLK_DIV, 4, clk cycles per sclk half-period; legal range ≥1.
- Derived (localparam, not overridable): TOTAL = WIDTH*CHIPS.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one scan; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- shld  out  1  registered shift/load_n to the chain; low = parallel load.
- sclk  out  1  registered shift clock to the chain.
- ser_in  in  1  chain serial output (q of the device nearest the reader).
- data_out  out  TOTAL  assembled word; held stable while valid is high.
- valid  out  1  data_out holds a completed scan.
- ready  in  1  consumer accepts data_out.
- overrun  out  1  one-cycle pulse when an unconsumed word is overwritten; constant 0 without the optional feature.

Behaviour:
- Reset (async assert, sync release) forces:
  - state IDLE; shld=1, sclk=0, valid=0, busy=0, overrun=0, data_out=0.
  - All counters 0.
  - Mid-scan reset abandons the scan; no partial word is ever presented.
- States: IDLE, LOAD, SETTLE, SHIFT_LO, SHIFT_HI, DONE.
- Divider tick: fires every CLK_DIV cycles. The divider restarts on every state change.
- IDLE:
  - start=1 → LOAD.
  - The bit index is cleared.
- LOAD:
  - shld=0 for CLK_DIV cycles, then → SETTLE.
- SETTLE:
  - shld=1, sclk=0 for CLK_DIV cycles, then → SHIFT_LO.
- SHIFT_LO:
  - sclk=0 for CLK_DIV cycles.
  - On the final cycle, ser_in is captured into shift-buffer bit [idx].
  - If idx==TOTAL-1 → DONE; otherwise idx increments → SHIFT_HI.
- SHIFT_HI:
  - sclk=1 for CLK_DIV cycles, then → SHIFT_LO.
  - The chain shifts on the sclk rising edge. The next sample is taken a full half-period later.
- Bit order: LSB first.
  - data_out[0] = parallel input bit 0 of the nearest device.
  - data_out[WIDTH*k + j] = bit j of device k, where k=0 is the nearest device.
- Exactly TOTAL-1 sclk rising edges are issued per scan.
- DONE:
  - data_out is loaded from the shift buffer and valid=1 on entry.
  - valid&&ready → valid=0 and → IDLE on the same edge.
  - start is not accepted until the following cycle, in IDLE.
- Latency: valid rises (2*TOTAL+1)*CLK_DIV + 1 cycles after the edge on which start is sampled.
- start while busy or in DONE: ignored and not queued.
- ready while valid=0: ignored.
- data_out changes only on DONE entry.
- shld and sclk are never low/high together: sclk=0 whenever shld=0.

Optional Feature:
- Macro: HC165_READER_AUTO_EN.
- Defined (free-running polling):
  - start is ignored. IDLE → LOAD automatically, one cycle after reset release and one cycle after each DONE entry.
  - DONE loads data_out, sets valid, and → IDLE without waiting for ready. valid clears on valid&&ready.
  - If valid is still 1 at the next DONE entry: data_out is overwritten, valid stays 1, and overrun pulses for 1 cycle.
  - If valid&&ready coincide with a DONE entry, valid stays 1 (new word) and there is no overrun.
- Undefined: start-triggered single-shot behaviour as above; overrun is tied 0.

Decomposition:
- Package hc165_pkg contains:
  - state encoding constants (IDLE..DONE, 3 bits);
  - a clog2-based width helper used for the bit-index and divider counters.
- Sub-module hc165_tick:
  - loadable down-counter producing the CLK_DIV tick;
  - restart input driven on each state change.

Test Plan:
- Single-shot readout: WIDTH=8, CHIPS=1, CLK_DIV=1, parallel in 8'hA5, start pulse at cycle 0 → shld low cycle 1; 7 sclk rising edges; valid at cycle 18; data_out=8'hA5; valid clears on ready.
- Two-chip ordering: CHIPS=2, CLK_DIV=3, device0=8'h3C, device1=8'hC1 → data_out=16'hC13C; sclk high/low phases each exactly 3 cycles.
- Ignored start: start held high through a whole scan with ready=0 → exactly one scan; busy stays high in DONE until ready; no second LOAD until the cycle after the handshake.
- Reset mid-operation: rst_n low during SHIFT_HI at idx=4 → shld=1, sclk=0, valid=0, data_out=0 immediately (asynchronously); after release, the next start yields a full correct word.
- Auto mode (HC165_READER_AUTO_EN): ready=0, inputs 8'h11 then 8'h22 → second DONE sets data_out=8'h22, overrun pulses once; ready asserted on a later DONE cycle → valid stays 1, no overrun.
- Invariant check across all runs: never (shld==0 && sclk==1); sclk rising-edge count per scan == TOTAL-1.

Source files
------------

// File: rtl/hc165_pkg.sv
// hc165_pkg: state encoding and counter sizing shared by the HC165 reader blocks.
package hc165_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SETTLE   = 3'd2,
        SHIFT_LO = 3'd3,
        SHIFT_HI = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hc165_reader_if.sv
// hc165_reader_if: chain pins plus the valid/ready word handshake of the HC165 reader.
interface hc165_reader_if #(
    parameter int W = 8
);
    logic         start;
    logic         busy;
    logic         shld;
    logic         sclk;
    logic         ser_in;
    logic [W-1:0] data_out;
    logic         valid;
    logic         ready;
    logic         overrun;

    modport master (
        input  start, ser_in, ready,
        output busy, shld, sclk, data_out, valid, overrun
    );

    modport slave (
        output start, ser_in, ready,
        input  busy, shld, sclk, data_out, valid, overrun
    );
endinterface

// File: rtl/hc165_tick.sv
// hc165_tick: divider that fires every DIV cycles and restarts its period on demand.
module hc165_tick
    import hc165_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int CW = cw(DIV);
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = cnt == '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= (restart || tick) ? TOP : cnt - 1'b1;
endmodule

// File: rtl/hc165_reader.sv
// hc165_reader: loads and shifts a daisy-chained HC165 string, presents the word via valid/ready.
// Define HC165_READER_AUTO_EN for free-running polling with overrun reporting.
module hc165_reader
    import hc165_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CHIPS   = 1,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    hc165_reader_if.master bus
);
    localparam int TOTAL = WIDTH * CHIPS;
    localparam int IW = cw(TOTAL);
    localparam logic [IW-1:0] LAST = IW'(TOTAL - 1);

    state_t state, state_n;
    logic tick, cap, entry, go, hold;
    logic shld_q, sclk_q, valid_q;
    logic [IW-1:0] idx;
    logic [TOTAL-1:0] sbuf, word, data_q;

`ifdef HC165_READER_AUTO_EN
    logic unused_start;
    logic overrun_q;
    assign unused_start = bus.start;
    assign go = 1'b1;
    assign hold = 1'b0;
    assign bus.overrun = overrun_q;
    // A finished word replaces one nobody took; a same-edge accept is not a loss.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) overrun_q <= 1'b0;
        else overrun_q <= entry && valid_q && !bus.ready;
`else
    assign go = bus.start;
    assign hold = !(valid_q && bus.ready);
    assign bus.overrun = 1'b0;
`endif

    hc165_tick #(.DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state_n != state),
        .tick    (tick)
    );

    assign cap = state == SHIFT_LO && tick;
    assign entry = state_n == DONE && state != DONE;
    assign bus.busy = state != IDLE;
    assign bus.shld = shld_q;
    assign bus.sclk = sclk_q;
    assign bus.valid = valid_q;
    assign bus.data_out = data_q;

    // Buffer with the bit being sampled this cycle already merged in.
    always_comb begin
        word = sbuf;
        word[idx] = bus.ser_in;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = go ? LOAD : IDLE;
            LOAD:     state_n = tick ? SETTLE : LOAD;
            SETTLE:   state_n = tick ? SHIFT_LO : SETTLE;
            SHIFT_LO: state_n = !tick ? SHIFT_LO : (idx == LAST) ? DONE : SHIFT_HI;
            SHIFT_HI: state_n = tick ? SHIFT_LO : SHIFT_HI;
            DONE:     state_n = hold ? DONE : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Pin outputs follow the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            sbuf    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            shld_q  <= 1'b1;
            sclk_q  <= 1'b0;
        end else begin
            state   <= state_n;
            shld_q  <= state_n != LOAD;
            sclk_q  <= state_n == SHIFT_HI;
            idx     <= (state == IDLE) ? '0 : (cap && idx != LAST) ? idx + 1'b1 : idx;
            sbuf    <= cap ? word : sbuf;
            data_q  <= entry ? word : data_q;
            valid_q <= entry || (valid_q && !bus.ready);
        end
endmodule

// File: tb/tb_hc165_reader.sv
// tb_hc165_reader: directed vectors against HC165 chain models for a 1-chip and a 2-chip reader.
module tb_hc165_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hc165_reader_if #(.W(8))  ia();
    hc165_reader_if #(.W(16)) ib();

    hc165_reader #(.WIDTH(8), .CHIPS(1), .CLK_DIV(1)) ua (.clk(clk), .rst_n(rst_n), .bus(ia));
    hc165_reader #(.WIDTH(8), .CHIPS(2), .CLK_DIV(3)) ub (.clk(clk), .rst_n(rst_n), .bus(ib));

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    // Chain models: parallel load while shld is low, shift toward q on each sclk rise.
    logic [7:0]  pa = 8'h00, sa = 8'h00;
    logic [15:0] pb = 16'h0000, sb = 16'h0000;
    logic sclk_a_d = 1'b0, shld_a_d = 1'b1, sclk_b_d = 1'b0;
    int rise_a = 0, loads_a = 0, rise_b = 0, viol = 0;
    int run_b = 0, ph_bad = 0, ph_n = 0;
    logic fell_b = 1'b0;

    assign ia.ser_in = sa[0];
    assign ib.ser_in = sb[0];

    always @(posedge clk) begin
        if (!ia.shld) begin
            sa <= pa;
            rise_a <= 0;
        end else if (ia.sclk && !sclk_a_d) begin
            sa <= sa >> 1;
            rise_a <= rise_a + 1;
        end
        if (!ia.shld && shld_a_d) loads_a <= loads_a + 1;
        if ((!ia.shld && ia.sclk) || (!ib.shld && ib.sclk)) viol <= viol + 1;
        sclk_a_d <= ia.sclk;
        shld_a_d <= ia.shld;
    end

    always @(posedge clk) begin
        if (!ib.shld) begin
            sb <= pb;
            rise_b <= 0;
            fell_b <= 1'b0;
            run_b <= 1;
        end else if (ib.sclk && !sclk_b_d) begin
            sb <= sb >> 1;
            rise_b <= rise_b + 1;
            if (fell_b && run_b != 3) ph_bad <= ph_bad + 1;
            run_b <= 1;
        end else if (!ib.sclk && sclk_b_d) begin
            if (run_b != 3) ph_bad <= ph_bad + 1;
            run_b <= 1;
            fell_b <= 1'b1;
            ph_n <= ph_n + 1;
        end else begin
            run_b <= run_b + 1;
        end
        sclk_b_d <= ib.sclk;
    end

    task automatic scan_a(input logic [7:0] p, output logic [7:0] d, output int lat, output int r,
                          output logic s1);
        pa = p;
        ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        lat = 1;
        s1 = ia.shld;
        while (!ia.valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        d = ia.data_out;
        r = rise_a;
    endtask

    task automatic scan_b(input logic [15:0] p, output logic [15:0] d, output int lat, output int r);
        pb = p;
        ib.start = 1'b1;
        @(posedge clk); #1;
        ib.start = 1'b0;
        lat = 1;
        while (!ib.valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        d = ib.data_out;
        r = rise_b;
    endtask

    typedef struct {
        logic [7:0] par;
        logic [7:0] exp;
    } va_t;

    typedef struct {
        logic [7:0]  dev0;
        logic [7:0]  dev1;
        logic [15:0] exp;
    } vb_t;

    va_t va[5];
    vb_t vb[4];

    initial begin
        logic [7:0] da;
        logic [15:0] db;
        int lat, r, n, l0;
        logic s1;
        va[0] = '{8'hA5, 8'hA5};
        va[1] = '{8'h00, 8'h00};
        va[2] = '{8'hFF, 8'hFF};
        va[3] = '{8'h01, 8'h01};
        va[4] = '{8'h80, 8'h80};
        vb[0] = '{8'h3C, 8'hC1, 16'hC13C};
        vb[1] = '{8'hFF, 8'h00, 16'h00FF};
        vb[2] = '{8'h01, 8'h80, 16'h8001};
        vb[3] = '{8'hA5, 8'h5A, 16'h5AA5};
        ia.start = 1'b0;
        ia.ready = 1'b0;
        ib.start = 1'b0;
        ib.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_shld", ia.shld, 1);
        chk("rst_sclk", ia.sclk, 0);
        chk("rst_valid", ia.valid, 0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_overrun", ia.overrun, 0);
        chk("rst_data", ia.data_out, 0);
`ifdef HC165_READER_AUTO_EN
        pa = 8'h11;
        rst_n = 1'b1;
        n = 0;
        while (!ia.valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("auto_first_data", ia.data_out, 8'h11);
        chk("auto_first_ovr", ia.overrun, 0);
        pa = 8'h22;
        n = 0;
        while (!ia.overrun && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("auto_ovr_pulse", ia.overrun, 1);
        chk("auto_ovr_data", ia.data_out, 8'h22);
        chk("auto_ovr_valid", ia.valid, 1);
        @(posedge clk); #1;
        chk("auto_ovr_one_cycle", ia.overrun, 0);
        pa = 8'h33;
        repeat (17) @(posedge clk);
        #1;
        chk("auto_pre_valid", ia.valid, 1);
        ia.ready = 1'b1;
        @(posedge clk); #1;
        chk("auto_coinc_valid", ia.valid, 1);
        chk("auto_coinc_ovr", ia.overrun, 0);
        chk("auto_coinc_data", ia.data_out, 8'h33);
        @(posedge clk); #1;
        chk("auto_accept", ia.valid, 0);
        ia.ready = 1'b0;
        chk("no_shld_sclk_overlap", viol, 0);
`else
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            scan_a(va[i].par, da, lat, r, s1);
            chk($sformatf("a%0d_shld_c1", i), s1, 0);
            chk($sformatf("a%0d_latency", i), lat, 18);
            chk($sformatf("a%0d_rises", i), r, 7);
            chk($sformatf("a%0d_data", i), da, va[i].exp);
            ia.ready = 1'b1;
            @(posedge clk); #1;
            ia.ready = 1'b0;
            chk($sformatf("a%0d_valid_clr", i), ia.valid, 0);
            chk($sformatf("a%0d_idle", i), ia.busy, 0);
        end
        // Start held high across a whole scan and an unread word.
        l0 = loads_a;
        pa = 8'h3C;
        ia.start = 1'b1;
        n = 0;
        while (!ia.valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("hold_valid", ia.valid, 1);
        chk("hold_busy", ia.busy, 1);
        chk("hold_data", ia.data_out, 8'h3C);
        chk("hold_one_load", loads_a - l0, 1);
        ia.ready = 1'b1;
        @(posedge clk); #1;
        ia.ready = 1'b0;
        chk("hs_valid_clr", ia.valid, 0);
        chk("hs_not_busy", ia.busy, 0);
        chk("hs_no_load_yet", ia.shld, 1);
        @(posedge clk); #1;
        ia.start = 1'b0;
        chk("relaunch_load", ia.shld, 0);
        n = 0;
        while (!ia.valid && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("relaunch_data", ia.data_out, 8'h3C);
        ia.ready = 1'b1;
        @(posedge clk); #1;
        ia.ready = 1'b0;
        // Asynchronous reset while sclk is high after bit 3 was sampled.
        pa = 8'h96;
        ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_sclk_high", ia.sclk, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_shld", ia.shld, 1);
        chk("mid_rst_sclk", ia.sclk, 0);
        chk("mid_rst_valid", ia.valid, 0);
        chk("mid_rst_data", ia.data_out, 0);
        chk("mid_rst_busy", ia.busy, 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        scan_a(8'h96, da, lat, r, s1);
        chk("post_rst_data", da, 8'h96);
        chk("post_rst_latency", lat, 18);
        ia.ready = 1'b1;
        @(posedge clk); #1;
        ia.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scan_b({vb[i].dev1, vb[i].dev0}, db, lat, r);
            chk($sformatf("b%0d_latency", i), lat, 100);
            chk($sformatf("b%0d_rises", i), r, 15);
            chk($sformatf("b%0d_data", i), db, vb[i].exp);
            ib.ready = 1'b1;
            @(posedge clk); #1;
            ib.ready = 1'b0;
            chk($sformatf("b%0d_valid_clr", i), ib.valid, 0);
        end
        chk("b_phase_len", ph_bad, 0);
        chk("b_phase_count", ph_n, 60);
        chk("no_shld_sclk_overlap", viol, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
